daq_multi_packetizer: RTL and testbench

- Parametrised successor of the single-AD7606 DAQ packetizer.
- Drives CONVST, CS and RD for NUM_ADC AD7606-style converters sharing one 16-bit data bus, and reads CH_PER_ADC samples per converter each conversion.
- Frames each conversion as a byte packet (header, sequence number, samples MSB-first) in an internal byte FIFO, emitted on a valid/ready stream toward the USB/host interface.
- Everything is synchronous to one clock; there are no derived clocks.

---
 rtl/daq_multi_packetizer.sv | 234 +++++++++++++++++++++++
 tb/tb_daq_multi_packetizer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_multi_packetizer.sv
// Sequences NUM_ADC AD7606-style converters on one shared bus and frames each conversion
// into a byte stream (A5, seq, samples MSB-first). Optional checksum byte: DAQ_PKT_CHECKSUM_EN.
module daq_multi_packetizer #(
  parameter int NUM_ADC     = 2,
  parameter int CH_PER_ADC  = 8,
  parameter int CONV_PERIOD = 1000,
  parameter int CONV_LOW    = 4,
  parameter int RD_LOW      = 3,
  parameter int RD_HIGH     = 2,
  parameter int BUSY_TO     = 255,
  parameter int FIFO_DEPTH  = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic               conv_o,
  input  logic [NUM_ADC-1:0] busy_i,
  input  logic               frstdata_i,
  output logic [NUM_ADC-1:0] cs_o,
  output logic               rd_o,
  input  logic [15:0]        db_i,
  output logic [7:0]         pkt_data_o,
  output logic               pkt_valid_o,
  input  logic               pkt_ready_i,
  output logic               pkt_sop_o,
  output logic               pkt_eop_o,
  output logic [15:0]        drop_cnt_o,
  output logic               timeout_o,
  output logic               frst_err_o
);
`ifdef DAQ_PKT_CHECKSUM_EN
  localparam int FRAME_BYTES = 3 + 2*NUM_ADC*CH_PER_ADC;
`else
  localparam int FRAME_BYTES = 2 + 2*NUM_ADC*CH_PER_ADC;
`endif
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = $clog2(CONV_PERIOD);
  localparam int AIW = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
  localparam int CIW = (CH_PER_ADC > 1) ? $clog2(CH_PER_ADC) : 1;
  localparam logic [AW:0]    DEPTH_V = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]    FB_V    = FRAME_BYTES[AW:0];
  localparam logic [15:0]    CL_M1   = 16'(CONV_LOW - 1);
  localparam logic [15:0]    BT_M1   = 16'(BUSY_TO - 1);
  localparam logic [15:0]    RL_M1   = 16'(RD_LOW - 1);
  localparam logic [15:0]    RH_M1   = 16'(RD_HIGH - 1);
  localparam logic [AIW-1:0] LAST_A  = AIW'(NUM_ADC - 1);
  localparam logic [CIW-1:0] LAST_C  = CIW'(CH_PER_ADC - 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT_HI, WAIT_LO, READ, DONE, ABORT} state_t;
  typedef enum logic [1:0] {R_LO, R_HI, R_GAP} rph_t;
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } entry_t;

  state_t         state;
  rph_t           rph;
  logic [15:0]    tmr;
  logic [AIW-1:0] adc;
  logic [CIW-1:0] ch;
  logic [7:0]     seq, samp_lsb;
  logic [PW-1:0]  per_cnt;
  logic           tick, push, pop, hold, last_smp;
  entry_t         push_e, head;
  entry_t         mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, frame_start, vis_ptr, used, free;

  assign tick = en_i && (per_cnt == PW'(CONV_PERIOD - 1));

  always_ff @(posedge clk_i)
    if (reset_i || !en_i || tick) per_cnt <= '0;
    else                          per_cnt <= per_cnt + 1'b1;

  // Bytes of a frame that can still abort stay invisible to the reader until READ.
  assign hold     = (state == CONV) || (state == WAIT_HI) || (state == WAIT_LO) || (state == ABORT);
  assign vis_ptr  = hold ? frame_start : wr_ptr;
  assign used     = wr_ptr - rd_ptr;
  assign free     = DEPTH_V - used;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign pkt_valid_o = (vis_ptr != rd_ptr);
  assign pkt_data_o  = head.data;
  assign pkt_sop_o   = pkt_valid_o & head.sop;
  assign pkt_eop_o   = pkt_valid_o & head.eop;
  assign pop         = pkt_valid_o & pkt_ready_i;
  assign last_smp    = (adc == LAST_A) && (ch == LAST_C);

`ifdef DAQ_PKT_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk_i)
    if (reset_i || (state == IDLE)) csum <= '0;
    else if (push)                  csum <= csum ^ push_e.data;
`endif

  // Header on the first CONV cycle, sequence on the second (CONV_LOW >= 2).
  always_comb begin
    push   = 1'b0;
    push_e = '0;
    case (state)
      CONV: begin
        if (tmr == 16'd0)      begin push = 1'b1; push_e = '{sop: 1'b1, eop: 1'b0, data: 8'hA5}; end
        else if (tmr == 16'd1) begin push = 1'b1; push_e = '{sop: 1'b0, eop: 1'b0, data: seq};   end
      end
      READ: begin
        if (rph == R_LO && tmr == RL_M1) begin
          push   = 1'b1;
          push_e = '{sop: 1'b0, eop: 1'b0, data: db_i[15:8]};
        end else if (rph == R_HI && tmr == 16'd0) begin
          push = 1'b1;
`ifdef DAQ_PKT_CHECKSUM_EN
          push_e = '{sop: 1'b0, eop: 1'b0, data: samp_lsb};
`else
          push_e = '{sop: 1'b0, eop: last_smp, data: samp_lsb};
`endif
        end
      end
`ifdef DAQ_PKT_CHECKSUM_EN
      DONE: begin push = 1'b1; push_e = '{sop: 1'b0, eop: 1'b1, data: csum}; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i)
    if (push && !reset_i) mem[wr_ptr[AW-1:0]] <= push_e;

  always_ff @(posedge clk_i)
    if (reset_i)  rd_ptr <= '0;
    else if (pop) rd_ptr <= rd_ptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      rph         <= R_LO;
      tmr         <= '0;
      adc         <= '0;
      ch          <= '0;
      seq         <= '0;
      samp_lsb    <= '0;
      wr_ptr      <= '0;
      frame_start <= '0;
      conv_o      <= 1'b1;
      cs_o        <= '1;
      rd_o        <= 1'b1;
      drop_cnt_o  <= '0;
      timeout_o   <= 1'b0;
      frst_err_o  <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE: if (tick) begin
          if (free >= FB_V) begin
            state       <= CONV;
            conv_o      <= 1'b0;
            tmr         <= '0;
            frame_start <= wr_ptr;
          end else begin
            if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            seq <= seq + 8'd1;
          end
        end
        CONV: begin
          tmr <= tmr + 16'd1;
          if (tmr == CL_M1) begin
            conv_o <= 1'b1;
            state  <= WAIT_HI;
            tmr    <= '0;
          end
        end
        WAIT_HI: begin
          tmr <= tmr + 16'd1;
          if (&busy_i)           begin state <= WAIT_LO; tmr <= '0; end
          else if (tmr == BT_M1) state <= ABORT;
        end
        WAIT_LO: begin
          tmr <= tmr + 16'd1;
          if (~|busy_i) begin
            state <= READ;
            rph   <= R_LO;
            tmr   <= '0;
            adc   <= '0;
            ch    <= '0;
            cs_o  <= ~NUM_ADC'(1);
            rd_o  <= 1'b0;
          end else if (tmr == BT_M1) state <= ABORT;
        end
        READ: begin
          tmr <= tmr + 16'd1;
          case (rph)
            R_LO: if (tmr == RL_M1) begin
              samp_lsb <= db_i[7:0];
              rd_o     <= 1'b1;
              rph      <= R_HI;
              tmr      <= '0;
              if (frstdata_i != (ch == '0)) frst_err_o <= 1'b1;
            end
            R_HI: if (tmr == RH_M1) begin
              tmr <= '0;
              if (ch == LAST_C) begin
                cs_o <= '1;
                ch   <= '0;
                if (adc == LAST_A) state <= DONE;
                else               rph   <= R_GAP;
              end else begin
                ch   <= ch + 1'b1;
                rd_o <= 1'b0;
                rph  <= R_LO;
              end
            end
            default: begin
              cs_o <= ~(NUM_ADC'(1) << (adc + 1'b1));
              adc  <= adc + 1'b1;
              rd_o <= 1'b0;
              rph  <= R_LO;
              tmr  <= '0;
            end
          endcase
        end
        DONE: begin
          seq   <= seq + 8'd1;
          state <= IDLE;
        end
        ABORT: begin
          timeout_o <= 1'b1;
          wr_ptr    <= frame_start;
          seq       <= seq + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_daq_multi_packetizer.sv
// Directed bench for daq_multi_packetizer: converter model (busy pulse, ramp bus, FRSTDATA)
// plus a stream collector; frames are compared against a byte model built here.
module tb_daq_multi_packetizer;
  localparam int NA = 2;
  localparam int CH = 8;
`ifdef DAQ_PKT_CHECKSUM_EN
  localparam int FB = 3 + 2*NA*CH;
`else
  localparam int FB = 2 + 2*NA*CH;
`endif

  logic          clk = 1'b0, reset = 1'b1, en = 1'b0, ready = 1'b0, frst = 1'b0;
  logic [NA-1:0] busy = '0;
  logic [15:0]   db = '0;
  logic          conv, rd, pvalid, psop, peop, tmo, ferr;
  logic [NA-1:0] cs;
  logic [7:0]    pdata;
  logic [15:0]   drop;

  daq_multi_packetizer dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .conv_o(conv), .busy_i(busy),
    .frstdata_i(frst), .cs_o(cs), .rd_o(rd), .db_i(db), .pkt_data_o(pdata),
    .pkt_valid_o(pvalid), .pkt_ready_i(ready), .pkt_sop_o(psop), .pkt_eop_o(peop),
    .drop_cnt_o(drop), .timeout_o(tmo), .frst_err_o(ferr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // converter model, updated on the falling edge
  int            idx = 0, bcnt = 0;
  logic          prev_conv = 1'b1, prev_rd = 1'b1, force_frst = 1'b0;
  logic [NA-1:0] stuck = '0;
  always @(negedge clk) begin
    if (!conv) idx = 0;
    else if (!prev_rd && rd) idx = idx + 1;
    if (!prev_conv && conv) bcnt = 50;
    else if (bcnt > 0) bcnt = bcnt - 1;
    prev_conv = conv;
    prev_rd   = rd;
    busy = (bcnt > 0) ? ~stuck : '0;
    db   = 16'h0100 + 16'(idx);
    frst = ((idx % CH) == 0) && !(force_frst && idx == CH);
  end

  // stream collector and hold-stability monitor
  logic [7:0] rxd[$];
  logic       rxs[$], rxe[$];
  logic       pv_q = 1'b0, pr_q = 1'b0;
  logic [9:0] pe_q = '0;
  int         stab_viol = 0;
  always @(negedge clk) begin
    if (reset) pv_q = 1'b0;
    else begin
      if (pv_q && !pr_q && (!pvalid || {psop, peop, pdata} != pe_q)) stab_viol++;
      if (pvalid && ready) begin
        rxd.push_back(pdata);
        rxs.push_back(psop);
        rxe.push_back(peop);
      end
      pv_q = pvalid;
      pr_q = ready;
      pe_q = {psop, peop, pdata};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rxd.delete(); rxs.delete(); rxe.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; ready = 1'b0; stuck = '0; force_frst = 1'b0;
    cyc(3);
    reset = 1'b0;
    clear_rx();
    cyc(1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_conv"}, conv, 1);
    chk({p, "_cs"}, cs, 2'b11);
    chk({p, "_rd"}, rd, 1);
    chk({p, "_valid"}, pvalid, 0);
    chk({p, "_sop"}, psop, 0);
    chk({p, "_eop"}, peop, 0);
    chk({p, "_drop"}, drop, 0);
    chk({p, "_timeout"}, tmo, 0);
    chk({p, "_frst_err"}, ferr, 0);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (rxd.size() < n && k < budget) begin cyc(1); k++; end
    chk({name, "_bytes_arrived"}, rxd.size() >= n, 1);
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] sq, input int k);
    logic [15:0] v;
    logic [7:0]  x;
`ifdef DAQ_PKT_CHECKSUM_EN
    if (k == FB - 1) begin
      x = 8'h00;
      for (int j = 0; j < FB - 1; j++) x = x ^ exp_byte(sq, j);
      return x;
    end
`endif
    if (k == 0) return 8'hA5;
    if (k == 1) return sq;
    v = 16'h0100 + 16'((k - 2) / 2);
    return ((k % 2) == 0) ? v[15:8] : v[7:0];
  endfunction

  task automatic check_frame(input int base, input logic [7:0] sq, input string name);
    for (int k = 0; k < FB; k++) begin
      if (base + k >= rxd.size()) begin
        chk($sformatf("%s_missing_%0d", name, k), 0, 1);
        return;
      end
      chk($sformatf("%s_data_%0d", name, k), rxd[base+k], exp_byte(sq, k));
      chk($sformatf("%s_sop_%0d", name, k), rxs[base+k], k == 0);
      chk($sformatf("%s_eop_%0d", name, k), rxe[base+k], k == FB - 1);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int   n;
    logic eop33;
`ifdef DAQ_PKT_CHECKSUM_EN
    eop33 = 1'b0;
`else
    eop33 = 1'b1;
`endif
    tbl[0] = '{0,  8'hA5, 1'b1, 1'b0};
    tbl[1] = '{1,  8'h00, 1'b0, 1'b0};
    tbl[2] = '{2,  8'h01, 1'b0, 1'b0};
    tbl[3] = '{3,  8'h00, 1'b0, 1'b0};
    tbl[4] = '{4,  8'h01, 1'b0, 1'b0};
    tbl[5] = '{5,  8'h01, 1'b0, 1'b0};
    tbl[6] = '{17, 8'h07, 1'b0, 1'b0};
    tbl[7] = '{18, 8'h01, 1'b0, 1'b0};
    tbl[8] = '{19, 8'h08, 1'b0, 1'b0};
    tbl[9] = '{33, 8'h0F, 1'b0, eop33};

    // basic packets
    do_reset();
    chk_reset("init");
    en = 1'b1; ready = 1'b1;
    n = 0;
    while (conv && n < 1100) begin cyc(1); n++; end
    chk("first_tick_cycles", n, 1000);
    n = 0;
    while (!conv && n < 20) begin cyc(1); n++; end
    chk("conv_low_cycles", n, 4);
    wait_bytes(2*FB, 2500, "basic");
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].idx < rxd.size()) begin
        chk($sformatf("tbl%0d_data", i), rxd[tbl[i].idx], tbl[i].data);
        chk($sformatf("tbl%0d_sop", i), rxs[tbl[i].idx], tbl[i].sop);
        chk($sformatf("tbl%0d_eop", i), rxe[tbl[i].idx], tbl[i].eop);
      end else chk($sformatf("tbl%0d_present", i), 0, 1);
    end
    check_frame(0, 8'h00, "pkt0");
    check_frame(FB, 8'h01, "pkt1");
`ifdef DAQ_PKT_CHECKSUM_EN
    if (rxd.size() >= FB) begin
      logic [7:0] x;
      x = 8'h00;
      for (int j = 0; j < FB - 1; j++) x = x ^ rxd[j];
      chk("checksum_xor", rxd[FB-1], x);
    end
`endif
    chk("no_frst_err", ferr, 0);
    chk("no_drops", drop, 0);

    // backpressure: three frames fit, the next two ticks are dropped
    do_reset();
    en = 1'b1; ready = 1'b0;
    cyc(5*1000 + 300);
    en = 1'b0;
    chk("bp_drop_cnt", drop, 2);
    chk("bp_nothing_sent", rxd.size(), 0);
    chk("bp_valid_held", pvalid, 1);
    ready = 1'b1;
    wait_bytes(3*FB, 500, "bp");
    cyc(20);
    chk("bp_total_bytes", rxd.size(), 3*FB);
    check_frame(0, 8'h00, "bp0");
    check_frame(FB, 8'h01, "bp1");
    check_frame(2*FB, 8'h02, "bp2");
    chk("bp_drained", pvalid, 0);

    // busy timeout on converter 1
    do_reset();
    stuck = 2'b10; en = 1'b1; ready = 1'b1;
    n = 0;
    while (conv && n < 1100) begin cyc(1); n++; end
    n = 0;
    while (!conv && n < 20) begin cyc(1); n++; end
    n = 0;
    while (!tmo && n < 400) begin cyc(1); n++; end
    chk("timeout_latency", n, 256);
    cyc(1);
    chk("timeout_one_cycle", tmo, 0);
    cyc(5);
    chk("abort_no_bytes", rxd.size(), 0);
    chk("abort_fifo_empty", pvalid, 0);
    stuck = '0;
    wait_bytes(FB, 1300, "after_abort");
    check_frame(0, 8'h01, "after_abort");

    // FRSTDATA error on adc1 ch0
    do_reset();
    force_frst = 1'b1; en = 1'b1; ready = 1'b1;
    wait_bytes(FB, 1300, "frst");
    cyc(5);
    chk("frst_err_set", ferr, 1);
    chk("frst_pkt_len", rxd.size(), FB);
    check_frame(0, 8'h00, "frst");
    force_frst = 1'b0;
    cyc(100);
    chk("frst_err_sticky", ferr, 1);

    // reset in the middle of READ (adc0 ch5)
    do_reset();
    en = 1'b1; ready = 1'b1;
    n = 0;
    while (!(idx == 5 && !rd && !cs[0]) && n < 1300) begin cyc(1); n++; end
    chk("reached_read_ch5", n < 1300, 1);
    reset = 1'b1;
    cyc(1);
    chk_reset("midrst");
    reset = 1'b0;
    clear_rx();
    wait_bytes(FB, 1300, "post_rst");
    check_frame(0, 8'h00, "post_rst");

    chk("stream_stable_under_stall", stab_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
